skew_wr_ctrl: RTL and testbench
===============================

Name: skew_wr_ctrl

Overview:
- Parametrised write-side sequencer for the systolic array's output memory bank.
- Turns one job request (base address, row count) into a diagonally skewed write-enable wavefront across WIDTH columns, plus a per-column write address.
- Column c starts writing c cycles after column 0, matching the array's output skew.
- Adds start/busy/done handshake, a programmable base address and row count, wrap-around addressing, and a stall input that freezes the wavefront.

Parameters:
- WIDTH, 16, number of array columns / memory lanes
- ADDR_W, 8, width of each per-column write address
- ROW_W, 8, width of the row-count input (max job length 2^ROW_W-1 rows)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only when busy=0 and done=0
- base_addr  in  ADDR_W  first address written by every column; latched on accept
- num_rows  in  ROW_W  rows written per column; latched on accept
- stall  in  1  freeze wavefront for the next cycle (downstream back-pressure)
- wr_en  out  WIDTH  per-column write enable; bit c = column c
- wr_addr  out  WIDTH*ADDR_W  per-column address; slice [c*ADDR_W +: ADDR_W] = column c
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after a job's final write cycle

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset: wr_en=0, wr_addr=0, busy=0, done=0, FSM=IDLE, all counters and latches cleared.
- Reset mid-job aborts the job. Outputs are at reset values in the cycle after the reset edge, with no partial writes afterwards.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 at edge e0 latches base_addr and num_rows. If num_rows=0, go to DONE; otherwise go to RUN.
  - RUN: advance the wavefront on every non-stalled edge. Go to DONE on the edge after the last write cycle.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; inputs are not re-latched.
- Wavefront, with no stalls, cycle j = j-th cycle after e0 (j=0 is the first cycle after e0):
  - wr_en[c]=1 iff c <= j <= c+num_rows-1.
  - Last write cycle is j = num_rows+WIDTH-2.
  - busy=1 for j = 0..num_rows+WIDTH-2; done=1 at j = num_rows+WIDTH-1.
- Enables ramp up one column per cycle, then hold all ones when num_rows >= WIDTH. They ramp down with column 0 finishing first.
- Implementation is free: e.g. an injection counter feeding a shift register.
- Address rule: while wr_en[c]=1, slice c = (base_addr_latched + k) mod 2^ADDR_W, where k = number of writes column c has already issued in this job (0 on its first write).
- When wr_en[c]=0, slice c holds its last value. Between jobs, all slices hold.
- Addresses wrap silently from 2^ADDR_W-1 to 0. No error flag.
- Stall:
  - stall=1 sampled at an edge during RUN forces wr_en=0 for the following cycle.
  - Wavefront position, per-column counts and addresses are frozen.
  - busy stays 1.
  - The first non-stalled edge resumes exactly where the job stopped: no write is skipped or repeated.
  - Each stalled cycle extends the job by one cycle.
  - stall is ignored in IDLE and DONE.
- Simultaneous stall with the final advance: the final pattern is delayed, and done follows the actual last write cycle.
- num_rows=0: accepted, no writes, busy never asserted, done at j=0.

Test Plan:
- Reset: assert reset for 2 cycles with start=1 -> wr_en=0, wr_addr=0, busy=0, done=0; no job starts.
- WIDTH=4, base=8'h10, num_rows=3 -> wr_en = 0001, 0011, 0111, 1110, 1100, 1000 for j=0..5:
  - column 0 addresses 10,11,12 at j=0..2; column 3 addresses 10,11,12 at j=3..5;
  - busy j=0..5, done pulse at j=6, then IDLE.
- Default WIDTH=16, base=8'hFE, num_rows=4 -> each column writes FE, FF, 00, 01 (wrap); wr_en reaches 16'h000F at j=3; done at j=19.
- WIDTH=4, num_rows=3, stall=1 at the edge ending j=1 for 2 cycles -> wr_en=0000 for those 2 cycles, then resume with 0111; column 1 addresses continue without skip or repeat; done 2 cycles later (j=8).
- start pulses during RUN and DONE with different base/num_rows -> ignored; a start in IDLE after done is accepted with the new values.
- num_rows=0 start -> no wr_en bits ever set, busy stays 0, done pulse in the cycle after accept.
- Reset mid-job at j=2 -> all outputs zero in the next cycle; a subsequent start runs a clean job.

Source files
------------

// File: rtl/skew_wr_ctrl.sv
// Write-side sequencer for the systolic array output bank: turns one job
// (base address, row count) into a diagonally skewed write-enable wavefront.
module skew_wr_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ROW_W-1:0]          num_rows,
    input  logic                      stall,
    output logic [WIDTH-1:0]          wr_en,
    output logic [WIDTH*ADDR_W-1:0]   wr_addr,
    output logic                      busy,
    output logic                      done
);

    // Step counter must reach num_rows+WIDTH-1 without overflowing.
    localparam int CNT_W = ROW_W + $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          step;
    logic [CNT_W-1:0]          step_next;
    logic [CNT_W-1:0]          last_step;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W-1:0]         base_next;
    logic [ROW_W-1:0]          rows_q;
    logic [ROW_W-1:0]          rows_next;
    logic [WIDTH-1:0]          wr_en_next;
    logic [WIDTH*ADDR_W-1:0]   wr_addr_next;
    logic                      busy_next;
    logic                      done_next;

    // step is the index of the wavefront pattern to be shown on the next
    // advance; once it reaches last_step the final write cycle has been shown.
    assign last_step = CNT_W'(rows_q) + CNT_W'(WIDTH) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            base_q  <= '0;
            rows_q  <= '0;
            wr_en   <= '0;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            step    <= step_next;
            base_q  <= base_next;
            rows_q  <= rows_next;
            wr_en   <= wr_en_next;
            wr_addr <= wr_addr_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        step_next    = step;
        base_next    = base_q;
        rows_next    = rows_q;
        wr_en_next   = '0;
        wr_addr_next = wr_addr;
        busy_next    = busy;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    base_next = base_addr;
                    rows_next = num_rows;
                    if (num_rows == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        // Pattern 0 is shown straight away: column 0 only.
                        state_next             = RUN;
                        busy_next              = 1'b1;
                        wr_en_next[0]          = 1'b1;
                        wr_addr_next[ADDR_W-1:0] = base_addr;
                        step_next              = CNT_W'(1);
                    end
                end
            end

            RUN: begin
                if (!stall) begin
                    if (step == last_step) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // A column writes contiguously across advances, so its
                        // held address plus one is the next address.
                        for (int c = 0; c < WIDTH; c++) begin
                            if ((CNT_W'(c) <= step) &&
                                ((step - CNT_W'(c)) < CNT_W'(rows_q))) begin
                                wr_en_next[c] = 1'b1;
                                wr_addr_next[c*ADDR_W +: ADDR_W] =
                                    (step == CNT_W'(c)) ? base_q :
                                    wr_addr[c*ADDR_W +: ADDR_W] + ADDR_W'(1);
                            end
                        end
                        step_next = step + CNT_W'(1);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                step_next  = '0;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_skew_wr_ctrl.sv
// Self-checking bench for skew_wr_ctrl: a 4-column and a default 16-column
// instance share stimulus; vectors are checked against hand-computed values.
module tb_skew_wr_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic [7:0]   base_addr;
    logic [7:0]   num_rows;
    logic         stall;

    logic [3:0]   en4;
    logic [31:0]  addr4;
    logic         busy4;
    logic         done4;
    logic [15:0]  en16;
    logic [127:0] addr16;
    logic         busy16;
    logic         done16;

    int errors = 0;
    int checks = 0;

    skew_wr_ctrl #(.WIDTH(4), .ADDR_W(8), .ROW_W(8)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .stall     (stall),
        .wr_en     (en4),
        .wr_addr   (addr4),
        .busy      (busy4),
        .done      (done4)
    );

    skew_wr_ctrl dut16 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .stall     (stall),
        .wr_en     (en16),
        .wr_addr   (addr16),
        .busy      (busy16),
        .done      (done16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic [7:0]  base;
        logic [7:0]  rows;
        logic        stall;
        logic [3:0]  en;
        logic [31:0] addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    // Expected sequence for the post-reset clean job (base 40, 2 rows).
    logic [3:0]  clean_en[6]   = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0};
    logic [31:0] clean_addr[6] = '{32'h00000040, 32'h00004041, 32'h00404141,
                                   32'h40414141, 32'h41414141, 32'h41414141};

    function automatic vec_t mk(logic s, logic [7:0] b, logic [7:0] r, logic st,
                                logic [3:0] e, logic [31:0] a, logic bz, logic d);
        vec_t v;
        v.start = s;  v.base = b;  v.rows = r;  v.stall = st;
        v.en    = e;  v.addr = a;  v.busy = bz; v.done  = d;
        return v;
    endfunction

    task automatic applyStimulus(input logic s, input logic [7:0] b,
                                 input logic [7:0] r, input logic st);
        start     = s;
        base_addr = b;
        num_rows  = r;
        stall     = st;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 200; k++) begin
            if (!busy4 && !busy16 && !done4 && !done16) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: timeout waiting for idle, busy4=%b busy16=%b expected 0",
                 name, busy4, busy16);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_en;
        logic [7:0]  exp_a;

        // Job A (base 10, 3 rows), start pulses in RUN and DONE are ignored,
        // then a 1-row job, then a job with a 2-cycle stall.
        vecs.push_back(mk(1, 8'h10, 8'd3, 0, 4'h1, 32'h00000010, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h3, 32'h00001011, 1, 0));
        vecs.push_back(mk(1, 8'h55, 8'd9, 0, 4'h7, 32'h00101112, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'hE, 32'h10111212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'hC, 32'h11121212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h8, 32'h12121212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h0, 32'h12121212, 0, 1));
        vecs.push_back(mk(1, 8'h55, 8'd9, 0, 4'h0, 32'h12121212, 0, 0));
        vecs.push_back(mk(1, 8'h20, 8'd1, 0, 4'h1, 32'h12121220, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h2, 32'h12122020, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h4, 32'h12202020, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h8, 32'h20202020, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h0, 32'h20202020, 0, 1));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h0, 32'h20202020, 0, 0));
        vecs.push_back(mk(1, 8'h10, 8'd3, 0, 4'h1, 32'h20202010, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h3, 32'h20201011, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 1, 4'h0, 32'h20201011, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 1, 4'h0, 32'h20201011, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h7, 32'h20101112, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'hE, 32'h10111212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'hC, 32'h11121212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h8, 32'h12121212, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h0, 32'h12121212, 0, 1));
        vecs.push_back(mk(0, 8'h00, 8'd0, 0, 4'h0, 32'h12121212, 0, 0));

        // Reset held for two edges with start asserted.
        reset = 1'b1;
        applyStimulus(1, 8'h33, 8'd5, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset en4", en4, 4'h0);
        checkOutput("reset addr4", addr4, 32'h0);
        checkOutput("reset busy4", busy4, 1'b0);
        checkOutput("reset done4", done4, 1'b0);
        checkOutput("reset en16", en16, 16'h0);
        checkOutput("reset addr16", addr16, 128'h0);
        reset = 1'b0;
        applyStimulus(0, 8'h00, 8'd0, 0);
        @(negedge clk);
        checkOutput("post-reset busy4", busy4, 1'b0);
        checkOutput("post-reset en4", en4, 4'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].base, vecs[i].rows, vecs[i].stall);
            @(negedge clk);
            checkOutput($sformatf("vec%0d en", i), en4, vecs[i].en);
            checkOutput($sformatf("vec%0d addr", i), addr4, vecs[i].addr);
            checkOutput($sformatf("vec%0d busy", i), busy4, vecs[i].busy);
            checkOutput($sformatf("vec%0d done", i), done4, vecs[i].done);
        end
        applyStimulus(0, 8'h00, 8'd0, 0);

        // 16 columns, base FE, 4 rows: every column writes FE, FF, 00, 01.
        waitIdle("fe idle");
        applyStimulus(1, 8'hFE, 8'd4, 0);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            applyStimulus(0, 8'h00, 8'd0, 0);
            for (int c = 0; c < 16; c++) exp_en[c] = (c <= j) && (j <= c + 3);
            checkOutput($sformatf("fe j%0d en", j), en16, exp_en);
            checkOutput($sformatf("fe j%0d busy", j), busy16, (j <= 18));
            checkOutput($sformatf("fe j%0d done", j), done16, (j == 19));
            for (int c = 0; c < 16; c++) begin
                if (exp_en[c]) begin
                    exp_a = 8'hFE + 8'(j - c);
                    checkOutput($sformatf("fe j%0d addr col%0d", j, c),
                                addr16[c*8 +: 8], exp_a);
                end
            end
        end
        checkOutput("fe final addr16", addr16, {16{8'h01}});

        // Zero-row job: done immediately, never busy, no writes.
        waitIdle("zero idle");
        applyStimulus(1, 8'h77, 8'd0, 0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'd0, 0);
        checkOutput("zero j0 en4", en4, 4'h0);
        checkOutput("zero j0 busy4", busy4, 1'b0);
        checkOutput("zero j0 done4", done4, 1'b1);
        checkOutput("zero j0 done16", done16, 1'b1);
        checkOutput("zero j0 en16", en16, 16'h0);
        @(negedge clk);
        checkOutput("zero j1 done4", done4, 1'b0);
        checkOutput("zero j1 busy4", busy4, 1'b0);
        checkOutput("zero j1 en4", en4, 4'h0);

        // Reset in the middle of a job, then a clean job.
        waitIdle("midreset idle");
        applyStimulus(1, 8'h30, 8'd3, 0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'd0, 0);
        checkOutput("midreset j0 en4", en4, 4'h1);
        @(negedge clk);
        checkOutput("midreset j1 en4", en4, 4'h3);
        @(negedge clk);
        checkOutput("midreset j2 en4", en4, 4'h7);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset en4", en4, 4'h0);
        checkOutput("midreset addr4", addr4, 32'h0);
        checkOutput("midreset busy4", busy4, 1'b0);
        checkOutput("midreset done4", done4, 1'b0);
        checkOutput("midreset en16", en16, 16'h0);
        checkOutput("midreset addr16", addr16, 128'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after reset en4", en4, 4'h0);
        checkOutput("after reset busy4", busy4, 1'b0);
        applyStimulus(1, 8'h40, 8'd2, 0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            applyStimulus(0, 8'h00, 8'd0, 0);
            checkOutput($sformatf("clean j%0d en", j), en4, clean_en[j]);
            checkOutput($sformatf("clean j%0d addr", j), addr4, clean_addr[j]);
            checkOutput($sformatf("clean j%0d busy", j), busy4, (j < 5));
            checkOutput($sformatf("clean j%0d done", j), done4, (j == 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
